// File: rtl/i2c_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the shared I2C master.
// The master modport is the arbiter's view; the slave modport is the
// environment's view (requesters plus I2C master).
interface i2c_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  // Requester side
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_op;
  logic [7*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   cmp_valid;
  logic [1:0]        cmp_code;
  logic [7:0]        cmp_rdata;
  // I2C master side
  logic              m_newd;
  logic              m_op;
  logic [6:0]        m_addr;
  logic [7:0]        m_din;
  logic [7:0]        m_dout;
  logic              m_busy;
  logic              m_ack_err;
  logic              m_done;

  modport master (
    input  req, req_op, req_addr, req_wdata, m_dout, m_busy, m_ack_err, m_done,
    output cmp_valid, cmp_code, cmp_rdata, m_newd, m_op, m_addr, m_din
  );

  modport slave (
    output req, req_op, req_addr, req_wdata, m_dout, m_busy, m_ack_err, m_done,
    input  cmp_valid, cmp_code, cmp_rdata, m_newd, m_op, m_addr, m_din
  );
endinterface

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C byte master among NREQ requesters.
// One transaction outstanding at a time; WAIT phase guarded by a 10-bit
// timeout counter. Optional single retry on ack error when the macro
// I2C_ARB_RETRY_EN is defined (default build: no retry).
module i2c_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  i2c_arbiter_if.master bus
);

  localparam int unsigned PW = (NREQ > 2) ? $clog2(NREQ) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StCmpl  = 2'd3;

  localparam logic [9:0]    CntLast = 10'(TIMEOUT - 1);
  localparam logic [PW-1:0] PtrLast = PW'(NREQ - 1);

  logic [1:0]      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [9:0]      cnt_q, cnt_d;
  logic            newd_q, newd_d;
  logic            op_q, op_d;
  logic [6:0]      addr_q, addr_d;
  logic [7:0]      din_q, din_d;
  logic [NREQ-1:0] cv_q, cv_d;
  logic [1:0]      code_q, code_d;
  logic [7:0]      rdata_q, rdata_d;
`ifdef I2C_ARB_RETRY_EN
  logic            retry_q, retry_d;
`endif

  logic            grant_any;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   grant_cand;
  logic [PW:0]     grant_sum;
  logic            grant_op;
  logic [6:0]      grant_addr;
  logic [7:0]      grant_wdata;

  // Round-robin search: scan offsets from the top down so the requester
  // closest to ptr (smallest offset) is the last and winning assignment.
  always_comb begin
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant_cand = '0;
    grant_sum  = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      grant_sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (grant_sum >= (PW+1)'(NREQ)) begin
        grant_sum = grant_sum - (PW+1)'(NREQ);
      end
      grant_cand = grant_sum[PW-1:0];
      if (bus.req[grant_cand]) begin
        grant_any = 1'b1;
        grant_idx = grant_cand;
      end
    end
  end

  // Fetch the winner's command fields with constant part-selects.
  always_comb begin
    grant_op    = 1'b0;
    grant_addr  = '0;
    grant_wdata = '0;
    for (int j = 0; j < int'(NREQ); j++) begin
      if (PW'(j) == grant_idx) begin
        grant_op    = bus.req_op[j];
        grant_addr  = bus.req_addr[7*j +: 7];
        grant_wdata = bus.req_wdata[8*j +: 8];
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    newd_d  = 1'b0;
    op_d    = op_q;
    addr_d  = addr_q;
    din_d   = din_q;
    cv_d    = '0;
    code_d  = 2'b00;
    rdata_d = '0;
`ifdef I2C_ARB_RETRY_EN
    retry_d = retry_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant_any && !bus.m_busy) begin
          state_d = StIssue;
          newd_d  = 1'b1;
          owner_d = grant_idx;
          ptr_d   = (grant_idx == PtrLast) ? '0 : grant_idx + PW'(1);
          op_d    = grant_op;
          addr_d  = grant_addr;
          din_d   = grant_wdata;
`ifdef I2C_ARB_RETRY_EN
          retry_d = 1'b0;
`endif
        end
      end
      StIssue: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        if (bus.m_done || bus.m_ack_err) begin
`ifdef I2C_ARB_RETRY_EN
          if (bus.m_ack_err && !retry_q) begin
            // First ack error of this grant: reissue the same command once.
            retry_d = 1'b1;
            state_d = StIssue;
            newd_d  = 1'b1;
          end else begin
            state_d        = StCmpl;
            cv_d[owner_q]  = 1'b1;
            code_d         = bus.m_ack_err ? 2'b01 : 2'b00;
            rdata_d        = (!bus.m_ack_err && op_q) ? bus.m_dout : 8'h00;
          end
`else
          state_d       = StCmpl;
          cv_d[owner_q] = 1'b1;
          code_d        = bus.m_ack_err ? 2'b01 : 2'b00;
          rdata_d       = (!bus.m_ack_err && op_q) ? bus.m_dout : 8'h00;
`endif
        end else if (cnt_q == CntLast) begin
          state_d       = StCmpl;
          cv_d[owner_q] = 1'b1;
          code_d        = 2'b10;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      StCmpl: begin
        state_d = StIdle;
        op_d    = 1'b0;
        addr_d  = '0;
        din_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      newd_q  <= 1'b0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      cv_q    <= '0;
      code_q  <= 2'b00;
      rdata_q <= '0;
`ifdef I2C_ARB_RETRY_EN
      retry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      newd_q  <= newd_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      cv_q    <= cv_d;
      code_q  <= code_d;
      rdata_q <= rdata_d;
`ifdef I2C_ARB_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  assign bus.m_newd    = newd_q;
  assign bus.m_op      = op_q;
  assign bus.m_addr    = addr_q;
  assign bus.m_din     = din_q;
  assign bus.cmp_valid = cv_q;
  assign bus.cmp_code  = code_q;
  assign bus.cmp_rdata = rdata_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_i2c_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 24;
`ifdef I2C_ARB_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  i2c_arbiter_if #(.NREQ(NREQ)) bus ();

  i2c_arbiter #(
    .NREQ   (NREQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the master, what it was told, how long it waited.
  int              m_ptr;
  int              m_owner;
  bit              m_issuing;
  bit              m_completing;
  bit              m_retried;
  int              m_waited;
  logic            e_newd, e_op;
  logic [6:0]      e_addr;
  logic [7:0]      e_din, e_rdata;
  logic [NREQ-1:0] e_cv;
  logic [1:0]      e_code;

  // Stimulus control
  int  resp_cnt;
  int  resp_kind;       // 0 done, 1 ack error, 2 never answers
  int  plan_q[$];
  int  plan_delay;
  int  fixed_dout;
  bit  rnd_mode;
  bit  hold_reqs;

  // Observations
  int  cyc;
  int  newd_cnt;
  int  last_newd_cyc;
  int  last_cmp_cyc;
  int  cmp_log[$];

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_issuing = 0; m_completing = 0; m_retried = 0; m_waited = 0;
    e_newd = 0; e_op = 0; e_addr = '0; e_din = '0; e_rdata = '0; e_cv = '0; e_code = '0;
    resp_cnt = -1; resp_kind = 0;
  endtask

  task automatic model_finish(input logic [1:0] code);
    e_cv          = '0;
    e_cv[m_owner] = 1'b1;
    e_code        = code;
    m_completing  = 1;
  endtask

  // Predict the outputs visible after the coming clock edge from current inputs.
  task automatic model_update();
    int w;
    e_newd = 0; e_cv = '0; e_code = '0; e_rdata = '0;
    if (m_completing) begin
      m_completing = 0; m_owner = -1;
      e_op = 0; e_addr = '0; e_din = '0;
    end else if (m_owner < 0) begin
      if (bus.req != '0 && !bus.m_busy) begin
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && bus.req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        m_owner = w;
        m_ptr   = (w + 1) % NREQ;
        e_op    = bus.req_op[w];
        e_addr  = bus.req_addr[7*w +: 7];
        e_din   = bus.req_wdata[8*w +: 8];
        m_retried = 0; m_issuing = 1; e_newd = 1;
      end
    end else if (m_issuing) begin
      m_issuing = 0; m_waited = 0;
    end else if (bus.m_done || bus.m_ack_err) begin
      if (bus.m_ack_err && RETRY && !m_retried) begin
        m_retried = 1; m_issuing = 1; e_newd = 1;
      end else begin
        model_finish(bus.m_ack_err ? 2'b01 : 2'b00);
        e_rdata = (!bus.m_ack_err && e_op) ? bus.m_dout : 8'h00;
      end
    end else begin
      m_waited++;
      if (m_waited == TIMEOUT) model_finish(2'b10);
    end
  endtask

  task automatic drive_master();
    int r;
    bus.m_done    = 1'b0;
    bus.m_ack_err = 1'b0;
    bus.m_dout    = (fixed_dout >= 0) ? 8'(fixed_dout) : 8'($urandom);
    if (rnd_mode) bus.m_busy = ($urandom % 5 == 0);
    if (e_newd) begin
      if (plan_q.size() > 0) resp_kind = plan_q.pop_front();
      else begin
        r = int'($urandom % 16);
        resp_kind = (r < 10) ? 0 : (r < 14) ? 1 : 2;
      end
      if (resp_kind == 2) resp_cnt = -1;
      else if (plan_delay > 0) resp_cnt = plan_delay;
      else resp_cnt = ($urandom % 8 == 0) ? TIMEOUT : 1 + int'($urandom % 4);
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        if (resp_kind == 1) bus.m_ack_err = 1'b1;
        else bus.m_done = 1'b1;
        resp_cnt = -1;
      end
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      if (e_cv[i] && !hold_reqs) begin
        if (!rnd_mode || $urandom % 2 == 0) bus.req[i] = 1'b0;
      end else if (rnd_mode) begin
        if (!bus.req[i]) begin
          if ($urandom % 4 == 0) begin
            bus.req[i]             = 1'b1;
            bus.req_op[i]          = 1'($urandom);
            bus.req_addr[7*i +: 7] = 7'($urandom);
            bus.req_wdata[8*i +: 8] = 8'($urandom);
          end
        end else if (i == m_owner && !m_completing && $urandom % 16 == 0) begin
          bus.req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    check("m_newd", 32'(bus.m_newd), 32'(e_newd));
    check("m_cmd", {bus.m_op, bus.m_addr, bus.m_din}, {e_op, e_addr, e_din});
    check("cmp_valid", 32'(bus.cmp_valid), 32'(e_cv));
    check("cmp_code", 32'(bus.cmp_code), 32'(e_code));
    check("cmp_rdata", 32'(bus.cmp_rdata), 32'(e_rdata));
    if (bus.m_newd) begin newd_cnt++; last_newd_cyc = cyc; end
    if (bus.cmp_valid != '0) begin
      last_cmp_cyc = cyc;
      for (int i = 0; i < NREQ; i++) if (bus.cmp_valid[i]) cmp_log.push_back(i);
    end
    drive_master();
    drive_reqs();
  endtask

  task automatic run_until_cmp(input int limit);
    int n = 0;
    do begin
      step();
      n++;
    end while (e_cv == '0 && n < limit);
    if (e_cv == '0) check("cmp_bound", 32'd0, 32'd1);
  endtask

  task automatic set_req(input int i, input logic op, input logic [6:0] a, input logic [7:0] d);
    bus.req[i] = 1'b1;
    bus.req_op[i] = op;
    bus.req_addr[7*i +: 7] = a;
    bus.req_wdata[8*i +: 8] = d;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.m_newd, bus.m_op, bus.m_addr, bus.m_din,
                bus.cmp_valid, bus.cmp_code, bus.cmp_rdata});
  endfunction

  // Asynchronous assert mid-cycle, synchronous-looking release on the falling edge.
  task automatic reset_dut();
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.req = '0; bus.req_op = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.m_dout = '0; bus.m_busy = 1'b0; bus.m_ack_err = 1'b0; bus.m_done = 1'b0;
    model_reset();
    plan_q.delete();
    plan_delay = 0; fixed_dout = -1; rnd_mode = 0; hold_reqs = 0;
    #1;
    check("rst_async", all_outs(), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_hold", all_outs(), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int exp_rr[5];
    cyc = 0; newd_cnt = 0; last_newd_cyc = 0; last_cmp_cyc = 0;
    exp_rr = '{0, 1, 2, 3, 0};

    reset_dut();

    // Single write, with m_busy blocking the grant first.
    plan_q = '{0}; plan_delay = 2;
    bus.m_busy = 1'b1;
    set_req(0, 1'b0, 7'h50, 8'hA5);
    repeat (3) step();
    check("busy_block", 32'(bus.m_newd), 32'd0);
    bus.m_busy = 1'b0;
    step();
    check("wr_newd", 32'(bus.m_newd), 32'd1);
    check("wr_addr", 32'(bus.m_addr), 32'h50);
    check("wr_din", 32'(bus.m_din), 32'hA5);
    run_until_cmp(40);
    check("wr_cv", 32'(bus.cmp_valid), 32'b0001);
    check("wr_code", 32'(bus.cmp_code), 32'd0);

    // Round-robin with all requests held.
    reset_dut();
    hold_reqs = 1; plan_q = '{0, 0, 0, 0, 0}; plan_delay = 1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 7'(8'h10 + i), 8'(i));
    cmp_log.delete();
    repeat (5) run_until_cmp(40);
    check("rr_count", 32'(cmp_log.size()), 32'd5);
    for (int k = 0; k < 5; k++)
      if (k < cmp_log.size()) check($sformatf("rr_order%0d", k), 32'(cmp_log[k]), 32'(exp_rr[k]));

    // Read on requester 2.
    reset_dut();
    plan_q = '{0}; fixed_dout = 8'h3C;
    set_req(2, 1'b1, 7'h20, 8'h00);
    run_until_cmp(40);
    check("rd_cv", 32'(bus.cmp_valid), 32'b0100);
    check("rd_rdata", 32'(bus.cmp_rdata), 32'h3C);
    check("rd_code", 32'(bus.cmp_code), 32'd0);

    // Ack error on the first attempt, success if reissued.
    reset_dut();
    plan_q = '{1, 0};
    newd_cnt = 0;
    set_req(1, 1'b0, 7'h11, 8'h22);
    run_until_cmp(60);
    check("ae_newd_cnt", 32'(newd_cnt), RETRY ? 32'd2 : 32'd1);
    check("ae_code", 32'(bus.cmp_code), RETRY ? 32'd0 : 32'd1);

    // Silent master: timeout after TIMEOUT cycles in WAIT.
    reset_dut();
    plan_q = '{2};
    set_req(3, 1'b1, 7'h33, 8'h44);
    run_until_cmp(TIMEOUT + 20);
    check("to_latency", 32'(last_cmp_cyc - last_newd_cyc), 32'(TIMEOUT + 1));
    check("to_code", 32'(bus.cmp_code), 32'd2);
    check("to_rdata", 32'(bus.cmp_rdata), 32'd0);

    // Done arriving on the terminal-count cycle wins over timeout.
    reset_dut();
    plan_q = '{0}; plan_delay = TIMEOUT;
    set_req(1, 1'b0, 7'h05, 8'h06);
    run_until_cmp(TIMEOUT + 20);
    check("tc_latency", 32'(last_cmp_cyc - last_newd_cyc), 32'(TIMEOUT + 1));
    check("tc_code", 32'(bus.cmp_code), 32'd0);

    // Reset in the middle of WAIT, then pointer must be back at 0.
    reset_dut();
    plan_q = '{2};
    set_req(0, 1'b0, 7'h0A, 8'h0B);
    repeat (6) step();
    check("mid_in_wait", 32'(m_owner), 32'd0);
    reset_dut();
    plan_q = '{0};
    set_req(0, 1'b0, 7'h01, 8'h02);
    set_req(1, 1'b0, 7'h03, 8'h04);
    run_until_cmp(40);
    check("ptr_after_rst", 32'(bus.cmp_valid), 32'b0001);

    // Randomized traffic.
    reset_dut();
    rnd_mode = 1;
    repeat (3000) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
